// File: rtl/online_multiplier_v3_if.sv
// Digit-stream interface of the online multiplier: start framing, input pair stream,
// product stream and status. master = producer/consumer side, slave = multiplier.
interface online_multiplier_v3_if;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] x_value;
   logic [1:0] y_value;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] p_value;
   logic       out_last;
   logic       busy;
   logic       err;

   modport master (
      output start, in_valid, x_value, y_value, out_ready,
      input  in_ready, out_valid, p_value, out_last, busy, err
   );

   modport slave (
      input  start, in_valid, x_value, y_value, out_ready,
      output in_ready, out_valid, p_value, out_last, busy, err
   );
endinterface

// File: rtl/online_multiplier_v3.sv
// Radix-2 MSD-first signed-digit multiplier with online delay DELTA.
// Define ONLINE_MULT_DIGIT_CHK_EN to build the sticky invalid-digit (11) flag on err.
module online_multiplier_v3 #(
   parameter int PRECISION = 64,
   parameter int DELTA     = 3,
   parameter int CNT_WIDTH = 9
) (
   input logic                  clk,
   input logic                  asyn_reset,
   online_multiplier_v3_if.slave bus
);
   localparam int XW = PRECISION + 2;
   localparam int WW = PRECISION + DELTA + 3;
   localparam int VW = WW + 2;
   localparam logic [CNT_WIDTH-1:0] P_C    = CNT_WIDTH'(PRECISION);
   localparam logic [CNT_WIDTH-1:0] D_C    = CNT_WIDTH'(DELTA);
   localparam logic [CNT_WIDTH-1:0] LAST_C = CNT_WIDTH'(PRECISION + DELTA);
   localparam logic [XW-1:0]        XONE_C = {{(XW-1){1'b0}}, 1'b1};
   localparam logic signed [VW-1:0] ONE_C  = {{(VW-1){1'b0}}, 1'b1} << (PRECISION + DELTA);
   localparam logic signed [VW-1:0] HALF_C = {{(VW-1){1'b0}}, 1'b1} << (PRECISION + DELTA - 1);
   localparam logic signed [VW-1:0] NHALF_C = -HALF_C;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   function automatic logic digit_pos(input logic [1:0] d);
      return (d == 2'b01);
   endfunction

   function automatic logic digit_neg(input logic [1:0] d);
      return (d == 2'b10);
   endfunction

   function automatic logic signed [XW-1:0] scale_xw(input logic [XW-1:0] wt, input logic pos,
                                                     input logic neg);
      if (pos) begin
         return $signed(wt);
      end else if (neg) begin
         return -$signed(wt);
      end else begin
         return '0;
      end
   endfunction

   function automatic logic signed [VW-1:0] scale_vw(input logic signed [VW-1:0] a, input logic pos,
                                                     input logic neg);
      if (pos) begin
         return a;
      end else if (neg) begin
         return -a;
      end else begin
         return '0;
      end
   endfunction

   state_e                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
   logic signed [WW-1:0]   w_q, w_d;
   logic                   out_valid_q, out_valid_d;
   logic [1:0]             p_value_q, p_value_d;
   logic                   out_last_q, out_last_d;
   logic                   busy_q, busy_d;

   logic [CNT_WIDTH-1:0]   k_s;
   logic                   need_in_s, emit_s, out_free_s, step_active_s, in_ready_s, fire_s;
   logic                   x_pos_s, x_neg_s, y_pos_s, y_neg_s, p_pos_s, p_neg_s;
   logic [XW-1:0]          wt_s;
   logic signed [XW-1:0]   x_new_s, y_new_s;
   logic signed [VW-1:0]   v_s;
   logic signed [WW-1:0]   w_new_s;

   // Datapath for the step at index k = cnt+1: operand append, residual and digit selection
   always_comb begin
      k_s           = cnt_q + CNT_WIDTH'(1);
      need_in_s     = (k_s <= P_C);
      emit_s        = (k_s > D_C);
      out_free_s    = !out_valid_q || bus.out_ready;
      step_active_s = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_FLUSH);
      in_ready_s    = step_active_s && need_in_s && (!emit_s || out_free_s);
      if (need_in_s) begin
         fire_s = bus.in_valid && in_ready_s;
      end else begin
         fire_s = step_active_s && (!emit_s || out_free_s);
      end
      // Code 11 decodes to neither flag, so it contributes as digit 0.
      x_pos_s = need_in_s && digit_pos(bus.x_value);
      x_neg_s = need_in_s && digit_neg(bus.x_value);
      y_pos_s = need_in_s && digit_pos(bus.y_value);
      y_neg_s = need_in_s && digit_neg(bus.y_value);
      if (need_in_s) begin
         wt_s = XONE_C << (P_C - k_s);
      end else begin
         wt_s = '0;
      end
      y_new_s = y_q + scale_xw(wt_s, y_pos_s, y_neg_s);
      x_new_s = x_q + scale_xw(wt_s, x_pos_s, x_neg_s);
      // The 2^-DELTA scaling lines operand LSBs up with residual LSBs, so no shift is needed.
      v_s = (VW'(w_q) <<< 1) + scale_vw(VW'(y_new_s), x_pos_s, x_neg_s)
            + scale_vw(VW'(x_q), y_pos_s, y_neg_s);
      p_pos_s = 1'b0;
      p_neg_s = 1'b0;
      if (emit_s) begin
         if (v_s >= HALF_C) begin
            p_pos_s = 1'b1;
         end else if (v_s < NHALF_C) begin
            p_neg_s = 1'b1;
         end else begin
            p_pos_s = 1'b0;
         end
      end else begin
         p_pos_s = 1'b0;
      end
      w_new_s = WW'(v_s - scale_vw(ONE_C, p_pos_s, p_neg_s));
   end

   // Next-state, operand/residual update and output register control
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      w_d         = w_q;
      out_valid_d = out_valid_q;
      p_value_d   = p_value_q;
      out_last_d  = out_last_q;
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               x_d     = '0;
               y_d     = '0;
               w_d     = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD, ST_RUN, ST_FLUSH: begin
            if (fire_s) begin
               cnt_d = k_s;
               x_d   = x_new_s;
               y_d   = y_new_s;
               w_d   = w_new_s;
               if (emit_s) begin
                  out_valid_d = 1'b1;
                  p_value_d   = {p_neg_s, p_pos_s};
                  out_last_d  = (k_s == LAST_C);
               end else begin
                  out_valid_d = out_valid_d;
               end
               if (k_s == LAST_C) begin
                  state_d = ST_DRAIN;
               end else if ((k_s >= P_C) && (k_s >= D_C)) begin
                  state_d = ST_FLUSH;
               end else if (k_s >= D_C) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_DRAIN: begin
            if (out_valid_q && bus.out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge asyn_reset) begin
      if (!asyn_reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         w_q         <= '0;
         out_valid_q <= 1'b0;
         p_value_q   <= 2'b00;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         w_q         <= w_d;
         out_valid_q <= out_valid_d;
         p_value_q   <= p_value_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
      end
   end

`ifdef ONLINE_MULT_DIGIT_CHK_EN
   function automatic logic digit_bad(input logic [1:0] d);
      return (d == 2'b11);
   endfunction

   logic err_q, err_d;

   // Sticky flag for an accepted 11-coded digit, cleared by an accepted start
   always_comb begin
      if ((state_q == ST_IDLE) && bus.start) begin
         err_d = 1'b0;
      end else if (bus.in_valid && in_ready_s && (digit_bad(bus.x_value) || digit_bad(bus.y_value))) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Error flag register
   always_ff @(posedge clk or negedge asyn_reset) begin
      if (!asyn_reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_q;
   assign bus.p_value   = p_value_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_online_multiplier_v3.sv
// Directed bench for online_multiplier_v3 (PRECISION=16, DELTA=3) with hand-computed
// digit expectations and an exact-product accuracy bound.
module tb_online_multiplier_v3;
   localparam int P  = 16;
   localparam int D  = 3;
   localparam int CW = 9;

   logic clk = 1'b0;
   logic asyn_reset;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;

   logic [1:0] xd [P];
   logic [1:0] yd [P];
   logic [1:0] pd [P];
   int   n_out, bad_code, stable_bad, last_bad, lat;
   logic err_last;
   logic exp_err;

   online_multiplier_v3_if bus ();

   online_multiplier_v3 #(.PRECISION(P), .DELTA(D), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .asyn_reset (asyn_reset),
      .bus        (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_value(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint dval(input logic [1:0] d);
      if (d == 2'b01) return 64'sd1;
      else if (d == 2'b10) return -64'sd1;
      else return 64'sd0;
   endfunction

   function automatic longint sum_p();
      longint s = 0;
      for (int i = 0; i < P; i++) s = 2 * s + dval(pd[i]);
      return s;
   endfunction

   task automatic check_product(input string tag);
      longint xv = 0;
      longint yv = 0;
      longint e;
      for (int i = 0; i < P; i++) begin
         xv = 2 * xv + dval(xd[i]);
         yv = 2 * yv + dval(yd[i]);
      end
      e = sum_p() * (64'sd1 << P) - xv * yv;
      if (e < 0) e = -e;
      check_value(tag, (e <= (64'sd1 << P)) ? 64'sd1 : 64'sd0, 64'sd1);
   endtask

   task automatic rand_digits();
      for (int i = 0; i < P; i++) begin
         xd[i] = 2'($urandom_range(2, 0));
         yd[i] = 2'($urandom_range(2, 0));
      end
   endtask

   // Starts an operation, streams xd/yd, collects P digits into pd (or stops after abort_after).
   task automatic run_op(input int in_gap, input int out_gap, input int mid_start, input int abort_after);
      int   xi = 0;
      int   cycles = 0;
      int   t_acc = cyc;
      logic holding = 1'b0;
      logic [1:0] held = 2'b00;
      n_out = 0; bad_code = 0; stable_bad = 0; last_bad = 0; lat = -1; err_last = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_value("busy_after_start", longint'(bus.busy), 64'sd1);
      while (n_out < P && cycles < 2000 && !(abort_after > 0 && n_out >= abort_after)) begin
         bus.in_valid  = (xi < P) && ($urandom_range(99, 0) >= in_gap);
         bus.x_value   = (xi < P) ? xd[xi] : 2'b00;
         bus.y_value   = (xi < P) ? yd[xi] : 2'b00;
         bus.out_ready = ($urandom_range(99, 0) >= out_gap);
         bus.start     = (mid_start > 0) && (cycles == mid_start);
         #1;
         if (holding && (!bus.out_valid || bus.p_value !== held)) stable_bad++;
         if (bus.in_valid && bus.in_ready && xi == 0) t_acc = cyc;
         if (bus.out_valid) begin
            if (bus.p_value == 2'b11) bad_code++;
            if (lat < 0) lat = cyc - t_acc;
         end
         if (bus.out_valid && bus.out_ready) begin
            pd[n_out] = bus.p_value;
            if (bus.out_last !== (n_out == P - 1)) last_bad++;
            if (n_out == P - 1) err_last = bus.err;
            n_out++;
            holding = 1'b0;
         end else if (bus.out_valid) begin
            holding = 1'b1;
            held    = bus.p_value;
         end else begin
            holding = 1'b0;
         end
         if (bus.in_valid && bus.in_ready) xi++;
         @(posedge clk); #1;
         cycles++;
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.start = 1'b0;
      if (abort_after == 0) begin
         check_value("digits_out", longint'(n_out), longint'(P));
         check_value("busy_idle", longint'(bus.busy), 64'sd0);
      end
   endtask

   task automatic check_single_one(input string tag);
      check_value({tag, "_p1"}, longint'(pd[0]), 64'sd1);
      check_value({tag, "_p2"}, longint'(pd[1]), 64'sd2);
      check_value({tag, "_sum"}, sum_p(), 64'sd16384);
      check_value({tag, "_last"}, longint'(last_bad), 64'sd0);
   endtask

   initial begin
`ifdef ONLINE_MULT_DIGIT_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      asyn_reset = 1'b0;
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.x_value = 2'b00; bus.y_value = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      check_value("reset_outs", longint'({bus.in_ready, bus.out_valid, bus.p_value,
                                          bus.out_last, bus.busy, bus.err}), 64'sd0);
      asyn_reset = 1'b1;
      @(posedge clk); #1;

      // x = y = 0.1000...: product exactly 1/4, digits +1, -1, then zeros.
      for (int i = 0; i < P; i++) begin xd[i] = 2'b00; yd[i] = 2'b00; end
      xd[0] = 2'b01; yd[0] = 2'b01;
      run_op(0, 0, 0, 0);
      check_single_one("half_sq");
      check_value("latency", longint'(lat), longint'(D + 1));

      // x all +1, y all -1: -(1-2^-16)^2 within one LSB, no 11 codes.
      for (int i = 0; i < P; i++) begin xd[i] = 2'b01; yd[i] = 2'b10; end
      run_op(0, 0, 0, 0);
      check_product("pos_neg_acc");
      check_value("pos_neg_no11", longint'(bad_code), 64'sd0);

      // Stalled streams, some with a start pulse mid-operation, back-to-back.
      for (int n = 0; n < 24; n++) begin
         rand_digits();
         run_op(30, 30, (n % 3 == 0) ? 6 : 0, 0);
         check_product("rand_acc");
         check_value("rand_stable", longint'(stable_bad), 64'sd0);
         check_value("rand_last", longint'(last_bad), 64'sd0);
         check_value("rand_no11", longint'(bad_code), 64'sd0);
      end

      // Asynchronous reset after 5 outputs, then a clean operation.
      rand_digits();
      run_op(0, 0, 0, 5);
      asyn_reset = 1'b0;
      #1;
      check_value("midop_reset_outs", longint'({bus.in_ready, bus.out_valid, bus.p_value,
                                                bus.out_last, bus.busy, bus.err}), 64'sd0);
      @(posedge clk); @(posedge clk); #1;
      asyn_reset = 1'b1;
      @(posedge clk); #1;
      check_value("post_reset_busy", longint'(bus.busy), 64'sd0);
      for (int i = 0; i < P; i++) begin xd[i] = 2'b00; yd[i] = 2'b00; end
      xd[0] = 2'b01; yd[0] = 2'b01;
      run_op(10, 10, 0, 0);
      check_single_one("after_reset");

      // Invalid digit on x_3 counts as 0; err reflects the build option.
      rand_digits();
      xd[2] = 2'b11;
      run_op(0, 0, 0, 0);
      check_value("err_at_last", longint'(err_last), longint'(exp_err));
      check_product("bad_digit_acc");
      rand_digits();
      run_op(0, 0, 0, 0);
      check_value("err_cleared", longint'(err_last), 64'sd0);
      check_product("after_err_acc");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
